sample_byte_serializer: RTL and testbench

//  Transmit-side counterpart of the byte-to-sample merger. Accepts parallel samples
//  (demodulator output or IQ words) into a small FIFO, slices each one into bytes MSB first,
//  and feeds them one at a time to uart_tx using its valid/busy handshake.

---
 rtl/sample_byte_serializer_pkg.sv | 23 ++
 rtl/sample_byte_serializer_fifo.sv | 72 +++++++
 rtl/sample_byte_serializer.sv | 147 ++++++++++++++
 tb/tb_sample_byte_serializer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_byte_serializer_pkg.sv
// Shared definitions for the sample-to-byte serializer.
//  - UART_BYTE_W : width of one byte handed to uart_tx
//  - ser_state_t : serializer FSM state encoding
//  - ptr_width() : pointer/counter width for a given number of positions (minimum 1)
package sample_byte_serializer_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4
    } ser_state_t;

    // Width needed to index n positions; never returns zero so that
    // degenerate parameter values still give legal vector ranges.
    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sample_byte_serializer_fifo.sv
// sample_fifo: synchronous single-clock FIFO with show-ahead read data.
// Ports:
//  clk, rst  clock and synchronous active-high reset
//  push      write wdata (ignored when full unless pop is also high)
//  pop       advance the head (ignored when empty)
//  wdata     data to write
//  rdata     current head entry, valid whenever empty is low
//  full      DEPTH entries stored
//  empty     no entries stored
//  count     number of entries stored (0..DEPTH)
module sample_fifo
    import sample_byte_serializer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_width(DEPTH):0] count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the head slot in the same cycle, so a write is still
    // legal when full as long as a read happens alongside it.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign rdata = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sample_byte_serializer.sv
// sample_byte_serializer: buffers parallel samples in a FIFO and hands them
// to uart_tx one byte at a time, MSB first, over a valid/busy handshake.
// Ports:
//  clk           logic clock (clk_logic domain)
//  rst           synchronous reset, active high
//  data_i        sample to send (8*WORD_BYTES bits)
//  valid_i       push data_i when high and ready_o is high
//  ready_o       FIFO can take a sample this cycle
//  tx_busy_i     uart_tx is shifting a byte
//  byte_o        byte for uart_tx, held until the next strobe
//  byte_valid_o  one-cycle strobe to uart_tx
//  empty_o       FIFO empty and FSM idle (every byte handed off)
//  overflow_o    sticky: valid_i seen while ready_o low; cleared by rst
module sample_byte_serializer
    import sample_byte_serializer_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int GUARD_CYC  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [UART_BYTE_W*WORD_BYTES-1:0] data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          tx_busy_i,
    output logic [UART_BYTE_W-1:0]        byte_o,
    output logic                          byte_valid_o,
    output logic                          empty_o,
    output logic                          overflow_o
);

    localparam int WORD_W = UART_BYTE_W * WORD_BYTES;
    localparam int IDX_W  = ptr_width(WORD_BYTES);
    localparam int GCNT_W = ptr_width(GUARD_CYC + 1);
    localparam int CNT_W  = ptr_width(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(WORD_BYTES - 1);
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYC - 1);

    ser_state_t        state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [UART_BYTE_W-1:0] byte_q;
    logic              overflow_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // The LOAD pop frees a slot in the same cycle, so a full FIFO still
    // accepts a sample then.
    assign ready_o   = !fifo_full || fifo_pop;
    assign fifo_push = valid_i && ready_o;

    sample_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (data_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        gcnt_d       = gcnt_q;
        fifo_pop     = 1'b0;
        byte_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_rdata;
                idx_d    = '0;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                byte_valid_o = 1'b1;
                gcnt_d       = '0;
                state_d      = (GUARD_CYC == 0) ? ST_WAIT : ST_GUARD;
            end
            ST_GUARD: begin
                // uart_tx raises busy a cycle or more after the strobe;
                // looking at it earlier would mistake "not yet busy" for "done".
                if (gcnt_q == GUARD_LAST) state_d = ST_WAIT;
                else                      gcnt_d  = gcnt_q + 1'b1;
            end
            ST_WAIT: begin
                if (!tx_busy_i) begin
                    if (idx_q != IDX_LAST) begin
                        shreg_d = shreg_q << UART_BYTE_W;
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end else if (!fifo_empty) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            gcnt_q     <= '0;
            byte_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            // Capture the outgoing byte on entry to SEND so byte_o is valid
            // with the strobe and stays put until the next one.
            if (state_d == ST_SEND) byte_q <= shreg_d[WORD_W-1 -: UART_BYTE_W];
            if (valid_i && !ready_o) overflow_q <= 1'b1;
        end
    end

    assign byte_o     = byte_q;
    assign overflow_o = overflow_q;
    assign empty_o    = (fifo_count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_sample_byte_serializer.sv
// Bench for sample_byte_serializer: a 2-byte and a 4-byte instance, each
// driven by a simple uart_tx busy model. Expected bytes are queued when a
// sample is pushed; a negedge monitor pops and compares on every strobe.
module tb_sample_byte_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- 2-byte instance ----------------
    logic        rst2 = 1'b1;
    logic [15:0] d2_data = '0;
    logic        d2_valid = 1'b0;
    logic        d2_ready, d2_busy, d2_bv, d2_empty, d2_ovf;
    logic [7:0]  d2_byte;
    logic        stuck2 = 1'b0;
    int          busy_cnt2 = 0;

    sample_byte_serializer #(.WORD_BYTES(2), .FIFO_DEPTH(8), .GUARD_CYC(1)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .data_i       (d2_data),
        .valid_i      (d2_valid),
        .ready_o      (d2_ready),
        .tx_busy_i    (d2_busy),
        .byte_o       (d2_byte),
        .byte_valid_o (d2_bv),
        .empty_o      (d2_empty),
        .overflow_o   (d2_ovf)
    );

    // ---------------- 4-byte instance ----------------
    logic        rst4 = 1'b1;
    logic [31:0] d4_data = '0;
    logic        d4_valid = 1'b0;
    logic        d4_ready, d4_busy, d4_bv, d4_empty, d4_ovf;
    logic [7:0]  d4_byte;
    int          busy_cnt4 = 0;

    sample_byte_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(8), .GUARD_CYC(1)) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .data_i       (d4_data),
        .valid_i      (d4_valid),
        .ready_o      (d4_ready),
        .tx_busy_i    (d4_busy),
        .byte_o       (d4_byte),
        .byte_valid_o (d4_bv),
        .empty_o      (d4_empty),
        .overflow_o   (d4_ovf)
    );

    // uart_tx model: busy for 10 cycles starting the cycle after a strobe.
    always @(posedge clk) begin
        if (d2_bv)              busy_cnt2 <= 10;
        else if (busy_cnt2 > 0) busy_cnt2 <= busy_cnt2 - 1;
        if (d4_bv)              busy_cnt4 <= 10;
        else if (busy_cnt4 > 0) busy_cnt4 <= busy_cnt4 - 1;
    end
    assign d2_busy = stuck2 || (busy_cnt2 != 0);
    assign d4_busy = (busy_cnt4 != 0);

    // ---------------- scoreboard ----------------
    logic [7:0] q2[$];
    logic [7:0] q4[$];
    int         sc2[$];
    int         sc4[$];

    initial begin
        forever begin
            @(negedge clk);
            if (d2_bv) begin
                sc2.push_back(cyc);
                if (q2.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dut2 unexpected strobe: got byte 0x%0h, expected no strobe (cycle %0d)", d2_byte, cyc);
                end else begin
                    check("dut2 byte", 32'(d2_byte), 32'(q2.pop_front()));
                end
            end
            if (d4_bv) begin
                sc4.push_back(cyc);
                if (q4.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dut4 unexpected strobe: got byte 0x%0h, expected no strobe (cycle %0d)", d4_byte, cyc);
                end else begin
                    check("dut4 byte", 32'(d4_byte), 32'(q4.pop_front()));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp2(input logic [15:0] d);
        q2.push_back(d[15:8]);
        q2.push_back(d[7:0]);
    endtask

    task automatic push2(input logic [15:0] d, input logic exp_ready);
        @(posedge clk); #1;
        check("dut2 ready_o at push", 32'(d2_ready), 32'(exp_ready));
        d2_valid = 1'b1;
        d2_data  = d;
        if (exp_ready) exp2(d);
    endtask

    task automatic idle2();
        @(posedge clk); #1;
        d2_valid = 1'b0;
    endtask

    task automatic reset2();
        @(posedge clk); #1;
        d2_valid = 1'b0;
        rst2     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
    endtask

    task automatic drain2(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (q2.size() == 0 && d2_empty) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    function automatic logic [15:0] fill_sample(input int i);
        return 16'h10E0 + 16'(i) * 16'h0101;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    initial begin
        int p;
        bit found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst2 = 1'b0;
        rst4 = 1'b0;
        check("reset dut2 byte_o", 32'(d2_byte), 32'h00);
        check("reset dut2 byte_valid_o", 32'(d2_bv), 32'd0);
        check("reset dut2 empty_o", 32'(d2_empty), 32'd1);
        check("reset dut2 ready_o", 32'(d2_ready), 32'd1);
        check("reset dut2 overflow_o", 32'(d2_ovf), 32'd0);
        check("reset dut4 byte_o", 32'(d4_byte), 32'h00);
        check("reset dut4 byte_valid_o", 32'(d4_bv), 32'd0);
        check("reset dut4 empty_o", 32'(d4_empty), 32'd1);
        check("reset dut4 ready_o", 32'(d4_ready), 32'd1);

        // Single sample: 12 then 34, first strobe 3 cycles after push
        sc2.delete();
        push2(16'h1234, 1'b1);
        p = cyc;
        idle2();
        drain2("single drain", 200);
        check("single strobe count", 32'(sc2.size()), 32'd2);
        if (sc2.size() >= 2) begin
            check("single first latency", 32'(sc2[0] - p), 32'd3);
            check("single byte spacing", 32'(sc2[1] - sc2[0]), 32'd12);
        end
        check("single empty_o", 32'(d2_empty), 32'd1);

        // IQ order on the 4-byte instance
        sc4.delete();
        @(posedge clk); #1;
        check("iq ready_o", 32'(d4_ready), 32'd1);
        d4_valid = 1'b1;
        d4_data  = 32'hDEADBEEF;
        q4.push_back(8'hDE);
        q4.push_back(8'hAD);
        q4.push_back(8'hBE);
        q4.push_back(8'hEF);
        @(posedge clk); #1;
        d4_valid = 1'b0;
        begin
            bit done4 = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                if (q4.size() == 0 && d4_empty) begin
                    done4 = 1'b1;
                    break;
                end
            end
            check("iq drain", 32'(done4), 32'd1);
        end
        check("iq strobe count", 32'(sc4.size()), 32'd4);

        // Back-to-back: 01 02 03 04 05 06, gaps 12 within a sample, 13 across
        sc2.delete();
        push2(16'h0102, 1'b1);
        p = cyc;
        push2(16'h0304, 1'b1);
        push2(16'h0506, 1'b1);
        idle2();
        drain2("b2b drain", 400);
        check("b2b strobe count", 32'(sc2.size()), 32'd6);
        if (sc2.size() == 6) begin
            check("b2b first latency", 32'(sc2[0] - p), 32'd3);
            for (int i = 1; i < 6; i++)
                check($sformatf("b2b gap %0d", i), 32'(sc2[i] - sc2[i-1]), (i % 2 == 1) ? 32'd12 : 32'd13);
        end

        // Full/overflow: busy stuck, 10 pushes, 9 accepted
        reset2();
        sc2.delete();
        stuck2 = 1'b1;
        for (int i = 0; i < 10; i++) push2(fill_sample(i), (i < 9) ? 1'b1 : 1'b0);
        idle2();
        check("overflow set", 32'(d2_ovf), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("overflow sticky while stalled", 32'(d2_ovf), 32'd1);
        check("ready_o low while full", 32'(d2_ready), 32'd0);
        stuck2 = 1'b0;
        drain2("overflow drain", 2000);
        check("overflow accepted bytes", 32'(sc2.size()), 32'd18);
        check("overflow sticky after drain", 32'(d2_ovf), 32'd1);

        // Simultaneous push/pop at full
        reset2();
        check("overflow cleared by reset", 32'(d2_ovf), 32'd0);
        sc2.delete();
        stuck2 = 1'b1;
        for (int i = 0; i < 9; i++) push2(fill_sample(i), 1'b1);
        idle2();
        repeat (3) @(posedge clk);
        #1;
        check("full before pop", 32'(d2_ready), 32'd0);
        stuck2 = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (d2_ready) begin
                d2_valid = 1'b1;
                d2_data  = 16'hC3C4;
                exp2(16'hC3C4);
                found = 1'b1;
                break;
            end
        end
        check("push/pop slot seen", 32'(found), 32'd1);
        idle2();
        check("still full after push/pop", 32'(d2_ready), 32'd0);
        check("no overflow on push/pop", 32'(d2_ovf), 32'd0);
        drain2("push/pop drain", 2000);
        check("push/pop total bytes", 32'(sc2.size()), 32'd20);
        check("no overflow after drain", 32'(d2_ovf), 32'd0);

        // Reset during SEND of A55A: A5 already handed off, 5A dropped
        sc2.delete();
        push2(16'hA55A, 1'b1);
        void'(q2.pop_back());
        idle2();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (d2_bv) begin
                found = 1'b1;
                break;
            end
        end
        check("mid-send strobe seen", 32'(found), 32'd1);
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        check("mid-send reset byte_o", 32'(d2_byte), 32'h00);
        check("mid-send reset byte_valid_o", 32'(d2_bv), 32'd0);
        check("mid-send reset empty_o", 32'(d2_empty), 32'd1);
        check("mid-send reset ready_o", 32'(d2_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("mid-send strobe count", 32'(sc2.size()), 32'd1);
        check("mid-send scoreboard empty", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
